// File: rtl/cfg_if.sv
// cfg_if: 4-bit-address / 8-bit-data four-phase configuration bus
interface cfg_if;
  logic       c_valid;
  logic [3:0] c_addr;
  logic [7:0] c_data;
  logic       c_ready;
  modport master(output c_valid, c_addr, c_data, input c_ready);
  modport slave(input c_valid, c_addr, c_data, output c_ready);
endinterface

// File: rtl/cfg_master.sv
// cfg_master: assembles {C,addr},data byte frames into timeout-guarded four-phase config writes
module cfg_master #(
  parameter int TIMEOUT = 1024,
  parameter int GAP     = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  cfg_if.master      bus,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic       err_frame,
  output logic       overrun
);
  localparam int MX = TIMEOUT > GAP ? TIMEOUT : GAP;
  localparam int W  = $clog2(MX) > 13 ? $clog2(MX) : 13;
  typedef enum logic [1:0] {IDLE, HDR, REQ, REL} state_t;
  state_t st;
  logic [W-1:0] cnt;
  logic t_last, g_last;
  assign t_last = cnt == W'(TIMEOUT - 1);
  assign g_last = cnt == W'(GAP - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      cnt         <= '0;
      bus.c_valid <= 1'b0;
      bus.c_addr  <= '0;
      bus.c_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_frame   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_frame   <= 1'b0;
      overrun     <= 1'b0;
      cnt         <= &cnt ? cnt : cnt + 1'b1;
      case (st)
        IDLE: if (rx_valid) begin
          if (rx_data[7:4] == 4'hC) begin
            bus.c_addr <= rx_data[3:0];
            cnt        <= '0;
            busy       <= 1'b1;
            st         <= HDR;
          end else err_frame <= 1'b1;
        end
        HDR: if (rx_valid) begin
          bus.c_data  <= rx_data;
          bus.c_valid <= 1'b1;
          cnt         <= '0;
          st          <= REQ;
        end else if (g_last) begin
          err_frame <= 1'b1;
          busy      <= 1'b0;
          st        <= IDLE;
        end
        REQ: begin
          overrun <= rx_valid;
          // an acknowledge arriving on the final allowed cycle still wins over the timeout
          if (bus.c_ready || t_last) begin
            bus.c_valid <= 1'b0;
            done        <= bus.c_ready;
            err_timeout <= !bus.c_ready;
            cnt         <= '0;
            st          <= REL;
          end
        end
        REL: begin
          overrun <= rx_valid;
          if (!bus.c_ready || t_last) begin
            err_timeout <= bus.c_ready;
            busy        <= 1'b0;
            st          <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cfg_master.sv
// tb_cfg_master: randomized frame-level checks of cfg_master against per-write outcome rules
module tb_cfg_master;
  localparam int T = 16, G = 32;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0;
  logic rx_valid = 0;
  logic busy, done, err_timeout, err_frame, overrun;
  cfg_if bus();
  cfg_master #(.TIMEOUT(T), .GAP(G)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .bus(bus.master),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_frame(err_frame), .overrun(overrun)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int g, input int lat,
                          input int hold, input bit ov);
    int vh, bz, nd, nt, no, nf, st, ex, rc;
    vh = 0; bz = 0; nd = 0; nt = 0; no = 0; nf = 0; st = 0; ex = 0; rc = 0;
    rx_data = {4'hC, a}; rx_valid = 1; tick; rx_valid = 0;
    chk("busy_hdr", busy, 1);
    chk("valid_hdr", bus.c_valid, 0);
    repeat (g - 1) tick;
    rx_data = d; rx_valid = 1; tick; rx_valid = 0;
    chk("valid_rise", bus.c_valid, 1);
    chk("addr", bus.c_addr, a);
    chk("data", bus.c_data, d);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (!busy) break;
      if (bus.c_valid) vh++; else bz++;
      if (bus.c_valid && (bus.c_addr != a || bus.c_data != d)) st++;
      if (cyc == lat && bus.c_valid) rc = hold;
      bus.c_ready = rc > 0;
      if (rc > 0) rc--;
      rx_valid = ov && cyc == 1;
      rx_data = {4'hC, 4'(~a)};
      tick;
      rx_valid = 0;
      nd += done; nt += err_timeout; no += overrun; nf += err_frame;
      if (done && (err_timeout || err_frame)) ex++;
    end
    bus.c_ready = 0;
    chk("valid_cycles", vh, lat <= T ? lat : T);
    chk("done_count", nd, lat <= T);
    chk("timeout_count", nt, (lat > T) + (lat <= T && hold > T));
    chk("release_cycles", bz, lat <= T ? (hold < T ? hold : T) : 1);
    chk("overrun_count", no, ov);
    chk("frame_err_count", nf, 0);
    chk("stable", st, 0);
    chk("exclusive", ex, 0);
    chk("idle_after", busy, 0);
  endtask
  initial begin
    int nb, nf, nv, h;
    bus.c_ready = 0;
    tick; tick;
    chk("rst_valid", bus.c_valid, 0);
    chk("rst_addr", bus.c_addr, 0);
    chk("rst_data", bus.c_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {done, err_timeout, err_frame, overrun}, 0);
    rst = 0; tick;
    do_write(4'h4, 8'h04, 1, 12, 2, 0);
    do_write(4'h8, 8'h02, 3, 200, 1, 0);
    do_write(4'h3, 8'h77, 2, 1, 1, 0);
    do_write(4'hA, 8'h5C, 1, T, 3, 1);
    do_write(4'h1, 8'hE1, G, 5, 20, 0);
    do_write(4'h6, 8'h99, 1, 4, 2, 0);
    h = $urandom_range(0, 15);
    if (h == 12) h = 5;
    rx_data = {4'(h), 4'h4}; rx_valid = 1; tick; rx_valid = 0;
    chk("bad_hdr_err", err_frame, 1);
    chk("bad_hdr_busy", busy, 0);
    tick;
    chk("bad_hdr_pulse", err_frame, 0);
    rx_data = 8'hC4; rx_valid = 1; tick; rx_valid = 0;
    nb = 0; nf = 0; nv = 0;
    for (int i = 0; i < G + 10; i++) begin
      if (busy) nb++;
      tick;
      nf += err_frame; nv += bus.c_valid;
    end
    chk("gap_busy", nb, G);
    chk("gap_err", nf, 1);
    chk("gap_valid", nv, 0);
    rx_data = 8'hC3; rx_valid = 1; tick;
    rx_data = 8'h5A; tick; rx_valid = 0;
    repeat (5) tick;
    chk("pre_rst_valid", bus.c_valid, 1);
    rst = 1; tick;
    chk("mid_rst_valid", bus.c_valid, 0);
    chk("mid_rst_addr", bus.c_addr, 0);
    chk("mid_rst_data", bus.c_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pulses", {done, err_timeout, err_frame, overrun}, 0);
    rst = 0; tick;
    chk("post_rst_pulses", {done, err_timeout, err_frame, overrun, busy}, 0);
    for (int i = 0; i < 30; i++)
      do_write(4'($urandom), 8'($urandom), $urandom_range(1, 6), $urandom_range(1, 20),
               $urandom_range(1, 20), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
